// File: rtl/idelay_stepper_if.sv
// Tap-write and readback bus between the idelay_scanner (master) and the
// idelay_stepper (slave).
//
// Handshake: hw_strobe is a one-cycle write qualifier with no ready. Every
// cycle where it is high, hw_addr/hw_data are taken in that cycle. The slave
// never stalls a write. Readback has no handshake: rb_val/rb_pend show
// rb_addr as it was one cycle earlier.
interface idelay_stepper_if;
    logic [3:0] hw_addr;
    logic [4:0] hw_data;
    logic       hw_strobe;
    logic [3:0] rb_addr;
    logic [4:0] rb_val;
    logic       rb_pend;

    modport master (
        output hw_addr, hw_data, hw_strobe, rb_addr,
        input  rb_val, rb_pend
    );

    modport slave (
        input  hw_addr, hw_data, hw_strobe, rb_addr,
        output rb_val, rb_pend
    );
endinterface

// File: rtl/idelay_stepper.sv
// idelay_stepper: turns absolute 5-bit tap writes for 16 lanes into
// single-step CE/INC pulses for IDELAY primitives in VARIABLE mode, and keeps
// a shadow copy of every lane's current tap for readback.
//
// Optional feature: define IDELAY_STEPPER_SETTLE_EN to make the idle gap
// after each CE pulse last SETTLE cycles (SETTLE >= 1). When the macro is
// undefined, the gap is always 1 cycle and SETTLE has no effect.
module idelay_stepper #(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    idelay_stepper_if.slave   bus,
    output logic [15:0]       idelay_ce,
    output logic              idelay_inc,
    output logic              busy,
    output logic [1:0]        dbg_state
);

`ifdef IDELAY_STEPPER_SETTLE_EN
    localparam bit SETTLE_EN = 1'b1;
`else
    localparam bit SETTLE_EN = 1'b0;
`endif

    localparam int GAP_LEN = SETTLE_EN ? SETTLE : 1;
    localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_PULSE  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t       state, state_nxt;
    logic [4:0]   cur    [16];
    logic [4:0]   target [16];
    logic [15:0]  pending, pending_nxt, clr_mask, set_mask;
    logic [3:0]   rr, lane_q, pick, cmp_lane;
    logic [GW-1:0] gap_cnt;
    logic [4:0]   cmp_cur, cmp_tgt;
    logic         cmp_eq, pend_clr, go_pulse;

    assign dbg_state = state;

    // Round-robin pick: first pending lane after rr, wrapping, rr itself last.
    always_comb begin : arb
        logic       found;
        logic [3:0] idx;
        pick  = rr;
        found = 1'b0;
        idx   = rr;
        for (int i = 1; i <= 16; i++) begin
            idx = rr + 4'(i);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Compare operands: SELECT uses the fresh pick, GAP the latched lane.
    always_comb begin
        cmp_lane = (state == S_SELECT) ? pick : lane_q;
        cmp_cur  = cur[cmp_lane];
        cmp_tgt  = target[cmp_lane];
        cmp_eq   = (cmp_cur == cmp_tgt);
    end

    // Next-state logic; target is re-read at every compare point.
    always_comb begin
        state_nxt = state;
        pend_clr  = 1'b0;
        go_pulse  = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (cmp_eq) begin
                    pend_clr  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    go_pulse  = 1'b1;
                    state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (cmp_eq) begin
                        pend_clr  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        go_pulse  = 1'b1;
                        state_nxt = S_PULSE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pending update: a new strobe on the lane being retired keeps it pending.
    always_comb begin
        clr_mask    = pend_clr ? (16'd1 << cmp_lane) : 16'd0;
        set_mask    = bus.hw_strobe ? (16'd1 << bus.hw_addr) : 16'd0;
        pending_nxt = (pending & ~clr_mask) | set_mask;
    end

    // FSM state, arbitration bookkeeping and pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= 16'd0;
            rr      <= 4'd15;
            lane_q  <= 4'd0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (state == S_SELECT) lane_q <= pick;
            if (pend_clr)          rr     <= cmp_lane;
        end
    end

    // Target capture and shadow tap tracking (one step per PULSE cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                cur[i]    <= 5'd0;
                target[i] <= 5'd0;
            end
        end else begin
            if (bus.hw_strobe) target[bus.hw_addr] <= bus.hw_data;
            if (state == S_PULSE) begin
                if (idelay_inc) cur[lane_q] <= cur[lane_q] + 5'd1;
                else            cur[lane_q] <= cur[lane_q] - 5'd1;
            end
        end
    end

    // Gap timer: loaded while pulsing, counts down to the compare cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == S_PULSE) begin
            gap_cnt <= GAP_INIT;
        end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Registered IDELAY controls; INC holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idelay_ce  <= 16'd0;
            idelay_inc <= 1'b0;
        end else begin
            idelay_ce <= go_pulse ? (16'd1 << cmp_lane) : 16'd0;
            if (go_pulse) idelay_inc <= (cmp_tgt > cmp_cur);
        end
    end

    // Registered status and readback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            bus.rb_val  <= 5'd0;
            bus.rb_pend <= 1'b0;
        end else begin
            busy        <= (|pending_nxt) || (state_nxt != S_IDLE);
            bus.rb_val  <= cur[bus.rb_addr];
            bus.rb_pend <= pending[bus.rb_addr];
        end
    end

endmodule

// File: tb/tb_idelay_stepper.sv
// Testbench for idelay_stepper: directed tap writes checked every cycle
// against a time-scheduled behavioural model, plus literal expectations on
// pulse counts, latency, ordering and reset behaviour.
module tb_idelay_stepper;

    localparam int TB_SETTLE = 4;
`ifdef IDELAY_STEPPER_SETTLE_EN
    localparam int GAP = TB_SETTLE;
`else
    localparam int GAP = 1;
`endif
    localparam int STEP = 1 + GAP;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    idelay_stepper_if bus ();
    logic [15:0] idelay_ce;
    logic        idelay_inc;
    logic        busy;
    logic [1:0]  dbg_state;

    idelay_stepper #(.SETTLE(TB_SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .idelay_ce  (idelay_ce),
        .idelay_inc (idelay_inc),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Service is tracked as a schedule: once a lane is pending the model
    // compares one cycle later, each mismatch yields a pulse in the next cycle
    // and the following compare GAP cycles after that pulse.
    logic [4:0]  m_cur [16];
    logic [4:0]  m_tgt [16];
    logic [15:0] m_pend;
    int          m_rr;
    bit          m_active;
    int          m_wait;
    bit          m_pulse;
    bit          m_dir;
    int          m_lane;
    logic [15:0] e_ce;
    logic        e_inc, e_busy, e_rbp;
    logic [4:0]  e_rbv;

    function automatic int rr_pick(input logic [15:0] pend, input int rr);
        for (int i = 1; i <= 16; i++) begin
            if (pend[(rr + i) % 16]) return (rr + i) % 16;
        end
        return rr;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_cur[i] = 5'd0;
            m_tgt[i] = 5'd0;
        end
        m_pend = 16'd0; m_rr = 15; m_active = 0; m_wait = 0;
        m_pulse = 0; m_dir = 0; m_lane = -1;
        e_ce = 16'd0; e_inc = 0; e_busy = 0; e_rbv = 5'd0; e_rbp = 0;
    endtask

    task automatic model_step();
        bit nxt_active = m_active;
        int nxt_wait   = m_wait;
        bit nxt_pulse  = 0;
        bit dir        = m_dir;
        int lane       = m_lane;
        bit clr        = 0;
        e_rbv = m_cur[bus.rb_addr];
        e_rbp = m_pend[bus.rb_addr];
        if (!m_active) begin
            if (m_pend != 16'd0) begin
                nxt_active = 1; nxt_wait = 0; lane = -1;
            end
        end else if (m_wait > 0) begin
            nxt_wait = m_wait - 1;
        end else begin
            if (lane < 0) lane = rr_pick(m_pend, m_rr);
            if (m_cur[lane] == m_tgt[lane]) begin
                clr = 1; nxt_active = 0;
            end else begin
                nxt_pulse = 1; dir = (m_tgt[lane] > m_cur[lane]); nxt_wait = GAP;
            end
        end
        if (m_pulse) m_cur[m_lane] = m_dir ? m_cur[m_lane] + 5'd1 : m_cur[m_lane] - 5'd1;
        if (clr) begin
            m_pend[lane] = 1'b0;
            m_rr = lane;
            lane = -1;
        end
        if (bus.hw_strobe) begin
            m_tgt[bus.hw_addr]  = bus.hw_data;
            m_pend[bus.hw_addr] = 1'b1;
        end
        m_active = nxt_active; m_wait = nxt_wait; m_pulse = nxt_pulse;
        m_dir = dir; m_lane = lane;
        e_ce   = m_pulse ? (16'd1 << m_lane) : 16'd0;
        e_inc  = m_dir;
        e_busy = (m_pend != 16'd0) || m_active;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- scoreboard / statistics ----------------
    logic [3:0] exp_q[$];
    bit         seq_en = 0;
    int         inc_cnt  [16];
    int         dec_cnt  [16];
    int         first_ce [16];
    int         ce_log[$];
    int         busy_cycles;

    function automatic int ce_lane(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) begin
            inc_cnt[i] = 0; dec_cnt[i] = 0; first_ce[i] = -1;
        end
        ce_log.delete();
        busy_cycles = 0;
    endtask

    // Compare process: every cycle out of reset, DUT against model.
    always @(negedge clk) begin
        if (!rst) begin
            check("ce", idelay_ce, e_ce);
            check("busy", busy, e_busy);
            check("rb_val", bus.rb_val, e_rbv);
            check("rb_pend", bus.rb_pend, e_rbp);
            if (e_ce != 16'd0) check("inc", idelay_inc, e_inc);
            if (busy) busy_cycles++;
            if (idelay_ce != 16'd0) begin
                int l;
                l = ce_lane(idelay_ce);
                if (idelay_inc) inc_cnt[l]++;
                else            dec_cnt[l]++;
                if (first_ce[l] < 0) first_ce[l] = cyc;
                ce_log.push_back(cyc);
                if (seq_en && exp_q.size() > 0) check("order", l, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; leaves the strobe low again at the next posedge+1.
    task automatic drive_write(input logic [3:0] a, input logic [4:0] d);
        bus.hw_addr   = a;
        bus.hw_data   = d;
        bus.hw_strobe = 1'b1;
        @(posedge clk); #1;
        bus.hw_strobe = 1'b0;
    endtask

    task automatic wait_quiet(input int max_cyc);
        bit ok = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("quiet_timeout", ok, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic read_lane(input logic [3:0] a, input string name, input logic [4:0] exp);
        @(posedge clk); #1;
        bus.rb_addr = a;
        @(posedge clk);
        @(negedge clk);
        check(name, bus.rb_val, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        bit hit;
        rst = 1'b1;
        bus.hw_addr = 4'd0; bus.hw_data = 5'd0; bus.hw_strobe = 1'b0; bus.rb_addr = 4'd0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_ce", idelay_ce, 16'd0);
        check("rst_busy", busy, 0);
        check("rst_rb_val", bus.rb_val, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ce", idelay_ce, 16'd0);
        check("post_rst_state", dbg_state, 0);

        // Lane 3 up to 5.
        clear_stats();
        @(posedge clk); #1;
        bus.rb_addr = 4'd3;
        t0 = cyc;
        drive_write(4'd3, 5'd5);
        wait_quiet(200);
        check("t1_inc_pulses", inc_cnt[3], 5);
        check("t1_dec_pulses", dec_cnt[3], 0);
        check("t1_first_ce_latency", first_ce[3] - t0, 3);
        if (ce_log.size() >= 2) check("t1_step_period", ce_log[1] - ce_log[0], STEP);
        else check("t1_step_period", ce_log.size(), 2);
        check("t1_busy_cycles", busy_cycles, 2 + 5 * STEP);
        check("t1_rb_val", bus.rb_val, 5);

        // Lane 3 back down to 2.
        clear_stats();
        @(posedge clk); #1;
        drive_write(4'd3, 5'd2);
        wait_quiet(200);
        check("t2_dec_pulses", dec_cnt[3], 3);
        check("t2_inc_pulses", inc_cnt[3], 0);
        check("t2_rb_val", bus.rb_val, 2);

        // From reset: lane 15 then lane 0 on consecutive cycles.
        do_reset();
        clear_stats();
        exp_q = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
        seq_en = 1;
        drive_write(4'd15, 5'd1);
        drive_write(4'd0, 5'd4);
        wait_quiet(200);
        seq_en = 0;
        check("t3_order_left", exp_q.size(), 0);
        check("t3_lane0_pulses", inc_cnt[0], 4);
        check("t3_lane15_pulses", inc_cnt[15], 1);
        check("t3_lane0_first", (first_ce[0] >= 0 && first_ce[0] < first_ce[15]), 1);

        // Lane 7 retarget mid-service: 20 then 10 after the 5th pulse.
        clear_stats();
        @(posedge clk); #1;
        drive_write(4'd7, 5'd20);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inc_cnt[7] >= 5) begin
                hit = 1;
                break;
            end
        end
        check("t4_reach5_timeout", hit, 1);
        @(posedge clk); #1;
        drive_write(4'd7, 5'd10);
        wait_quiet(200);
        check("t4_inc_pulses", inc_cnt[7], 10);
        check("t4_dec_pulses", dec_cnt[7], 0);
        read_lane(4'd7, "t4_rb_val", 5'd10);

        // Write lane 0 to its current value (4): no steps.
        @(posedge clk); #1;
        bus.rb_addr = 4'd0;
        clear_stats();
        drive_write(4'd0, 5'd4);
        wait_quiet(50);
        repeat (2) @(negedge clk);
        check("t5_no_pulses", ce_log.size(), 0);
        check("t5_busy_cycles", busy_cycles, 2);
        check("t5_rb_pend", bus.rb_pend, 0);
        check("t5_rb_val", bus.rb_val, 4);

        // Reset in the middle of a pulse.
        clear_stats();
        @(posedge clk); #1;
        drive_write(4'd5, 5'd9);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (idelay_ce[5]) begin
                hit = 1;
                break;
            end
        end
        check("t6_pulse_timeout", hit, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_ce_async", idelay_ce, 16'd0);
        check("t6_busy_async", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int l = 0; l < 16; l++) begin
            read_lane(4'(l), "t6_rb_val_zero", 5'd0);
        end
        check("t6_state_idle", dbg_state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "time limit reached");
    end

endmodule
